// File: rtl/move_sequencer_pkg.sv
// Shared types and defaults for the special-register move sequencer (mfhi/mflo/mthi/mtlo).
package move_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T0,
    T1,
    MEMW,
    T2,
    T3,
    HOLD
  } state_e;

  localparam logic [4:0] OP_MFHI_DEF = 5'b11000;
  localparam logic [4:0] OP_MFLO_DEF = 5'b11001;
  localparam logic [4:0] OP_MTHI_DEF = 5'b10110;
  localparam logic [4:0] OP_MTLO_DEF = 5'b10111;
  localparam int         ALU_INC_DEF = 12;

  // Strobes that depend on the state alone; the sequencer registers these from the next state.
  typedef struct packed {
    logic pcOut;
    logic marIn;
    logic zIn;
    logic zLowOut;
    logic pcIn;
    logic read;
    logic mdrOut;
    logic irIn;
    logic aluInc;
    logic busy;
  } strobes_t;

  function automatic strobes_t stateStrobes(state_e s);
    strobes_t st;
    st = '0;
    case (s)
      T0: begin
        st.pcOut  = 1'b1;
        st.marIn  = 1'b1;
        st.zIn    = 1'b1;
        st.aluInc = 1'b1;
        st.busy   = 1'b1;
      end
      T1: begin
        st.zLowOut = 1'b1;
        st.pcIn    = 1'b1;
        st.read    = 1'b1;
        st.busy    = 1'b1;
      end
      MEMW: begin
        st.read = 1'b1;
        st.busy = 1'b1;
      end
      T2: begin
        st.mdrOut = 1'b1;
        st.irIn   = 1'b1;
        st.busy   = 1'b1;
      end
      T3:      st.busy = 1'b1;
      HOLD:    st.busy = 1'b1;
      default: st = '0;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Control bus between the move sequencer (master) and Datapath2 (slave).
// SINGLE_STEP_EN adds the step input.
interface move_sequencer_if #(
  parameter int OP_W  = 5,
  parameter int ALU_W = 5
);

  logic             run;
  logic [OP_W-1:0]  opcode;
  logic             mem_ready;
`ifdef SINGLE_STEP_EN
  logic             step;
`endif

  logic             PCout, MARin, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin;
  logic             Gra, Rin, Rout, HIin, HIout, LOin, LOout;
  logic [ALU_W-1:0] alu_op;
  logic             busy, err_illegal, err_timeout, instr_done;

  modport master (
    input  run, opcode, mem_ready,
`ifdef SINGLE_STEP_EN
    input  step,
`endif
    output PCout, MARin, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin,
    output Gra, Rin, Rout, HIin, HIout, LOin, LOout,
    output alu_op, busy, err_illegal, err_timeout, instr_done
  );

  modport slave (
    output run, opcode, mem_ready,
`ifdef SINGLE_STEP_EN
    output step,
`endif
    input  PCout, MARin, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin,
    input  Gra, Rin, Rout, HIin, HIout, LOin, LOout,
    input  alu_op, busy, err_illegal, err_timeout, instr_done
  );

endinterface

// File: rtl/move_sequencer_decode.sv
// Opcode decoder for the special-register moves: which register (HI/LO), which direction, and legality.
module move_decode
  import move_seq_pkg::*;
#(
  parameter int              OP_W    = 5,
  parameter logic [OP_W-1:0] OP_MFHI = OP_W'(OP_MFHI_DEF),
  parameter logic [OP_W-1:0] OP_MFLO = OP_W'(OP_MFLO_DEF),
  parameter logic [OP_W-1:0] OP_MTHI = OP_W'(OP_MTHI_DEF),
  parameter logic [OP_W-1:0] OP_MTLO = OP_W'(OP_MTLO_DEF)
) (
  input  logic [OP_W-1:0] i_opcode,
  output logic            o_selHi,
  output logic            o_toSpecial,
  output logic            o_legal
);

  // o_toSpecial=1 means the general register is copied into HI/LO (mthi/mtlo).
  always_comb begin
    o_selHi     = 1'b0;
    o_toSpecial = 1'b0;
    o_legal     = 1'b1;
    case (i_opcode)
      OP_MFHI: o_selHi = 1'b1;
      OP_MFLO: o_selHi = 1'b0;
      OP_MTHI: begin
        o_selHi     = 1'b1;
        o_toSpecial = 1'b1;
      end
      OP_MTLO: o_toSpecial = 1'b1;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/move_sequencer.sv
// Fetch/execute control sequencer for mfhi/mflo/mthi/mtlo with memory-wait timeout and illegal-opcode trap.
// Optional macro SINGLE_STEP_EN: park in HOLD after each instruction until step is pulsed.
module move_sequencer
  import move_seq_pkg::*;
#(
  parameter int              OP_W     = 5,
  parameter int              ALU_W    = 5,
  parameter int              ALU_INC  = ALU_INC_DEF,
  parameter logic [OP_W-1:0] OP_MFHI  = OP_W'(OP_MFHI_DEF),
  parameter logic [OP_W-1:0] OP_MFLO  = OP_W'(OP_MFLO_DEF),
  parameter logic [OP_W-1:0] OP_MTHI  = OP_W'(OP_MTHI_DEF),
  parameter logic [OP_W-1:0] OP_MTLO  = OP_W'(OP_MTLO_DEF),
  parameter int              WAIT_MAX = 15
) (
  input logic              clk,
  input logic              clr,
  move_sequencer_if.master bus
);

  localparam logic [8:0] WAIT_LIM = 9'(WAIT_MAX);

  state_e     r_state;
  strobes_t   r_strb;
  logic [7:0] r_waitCnt;
  logic       r_errIllegal;
  logic       r_errTimeout;

  state_e     w_nextState;
  logic [8:0] w_cntNext;
  logic       w_timeout;
  logic       w_selHi;
  logic       w_toSpecial;
  logic       w_legal;
  logic       w_exec;

  move_decode #(
    .OP_W    (OP_W),
    .OP_MFHI (OP_MFHI),
    .OP_MFLO (OP_MFLO),
    .OP_MTHI (OP_MTHI),
    .OP_MTLO (OP_MTLO)
  ) u_decode (
    .i_opcode    (bus.opcode),
    .o_selHi     (w_selHi),
    .o_toSpecial (w_toSpecial),
    .o_legal     (w_legal)
  );

  // One extra bit so the compare against WAIT_MAX cannot be fooled by an 8-bit wrap.
  assign w_cntNext = {1'b0, r_waitCnt} + 9'd1;

  always_comb begin
    w_nextState = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: if (bus.run) w_nextState = T0;
      T0:   w_nextState = T1;
      T1:   w_nextState = MEMW;
      MEMW: begin
        if (bus.mem_ready) begin
          w_nextState = T2;
        end else if (w_cntNext == WAIT_LIM) begin
          w_nextState = IDLE;
          w_timeout   = 1'b1;
        end
      end
      T2:   w_nextState = T3;
      T3: begin
        if (!w_legal) begin
          w_nextState = IDLE;
        end else begin
`ifdef SINGLE_STEP_EN
          w_nextState = HOLD;
`else
          w_nextState = bus.run ? T0 : IDLE;
`endif
        end
      end
      HOLD: begin
`ifdef SINGLE_STEP_EN
        if (!bus.run)     w_nextState = IDLE;
        else if (bus.step) w_nextState = T0;
`else
        w_nextState = IDLE;
`endif
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Counter is held at zero outside MEMW, so every MEMW visit starts counting from 0.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state      <= IDLE;
      r_strb       <= '0;
      r_waitCnt    <= '0;
      r_errIllegal <= 1'b0;
      r_errTimeout <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_strb    <= stateStrobes(w_nextState);
      r_waitCnt <= (r_state == MEMW) ? w_cntNext[7:0] : 8'd0;
      if (r_state == T3 && !w_legal) r_errIllegal <= 1'b1;
      if (w_timeout)                 r_errTimeout <= 1'b1;
    end
  end

  assign w_exec = (r_state == T3) && w_legal;

  assign bus.PCout       = r_strb.pcOut;
  assign bus.MARin       = r_strb.marIn;
  assign bus.Zin         = r_strb.zIn;
  assign bus.Zlowout     = r_strb.zLowOut;
  assign bus.PCin        = r_strb.pcIn;
  assign bus.Read        = r_strb.read;
  assign bus.MDRout      = r_strb.mdrOut;
  assign bus.IRin        = r_strb.irIn;
  assign bus.busy        = r_strb.busy;
  assign bus.alu_op      = r_strb.aluInc ? ALU_W'(ALU_INC) : '0;
  assign bus.err_illegal = r_errIllegal;
  assign bus.err_timeout = r_errTimeout;

  // MDRin follows mem_ready directly because read data is valid only in the cycle it is flagged,
  // and the T3 strobes depend on the opcode, which only becomes valid once IR is loaded.
  assign bus.MDRin      = (r_state == MEMW) && bus.mem_ready;
  assign bus.Gra        = w_exec;
  assign bus.Rin        = w_exec && !w_toSpecial;
  assign bus.Rout       = w_exec && w_toSpecial;
  assign bus.HIout      = w_exec && !w_toSpecial && w_selHi;
  assign bus.LOout      = w_exec && !w_toSpecial && !w_selHi;
  assign bus.HIin       = w_exec && w_toSpecial && w_selHi;
  assign bus.LOin       = w_exec && w_toSpecial && !w_selHi;
  assign bus.instr_done = w_exec;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed, table-driven bench for move_sequencer: one vector per clock, outputs compared mid-cycle.
module tb_move_sequencer;

  logic clk = 1'b0;
  logic clr;
  logic armed = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  move_sequencer_if #(.OP_W(5), .ALU_W(5)) bus ();

  move_sequencer dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  localparam logic [4:0] MFHI = 5'b11000;
  localparam logic [4:0] MFLO = 5'b11001;
  localparam logic [4:0] MTHI = 5'b10110;
  localparam logic [4:0] MTLO = 5'b10111;
  localparam logic [4:0] ILL  = 5'b00000;

  // Bit order: PCout MARin Zin Zlowout PCin Read MDRin MDRout IRin Gra Rin Rout HIin HIout LOin LOout
  localparam logic [15:0] Z       = 16'b0000_0000_0000_0000;
  localparam logic [15:0] ST_T0   = 16'b1110_0000_0000_0000;
  localparam logic [15:0] ST_T1   = 16'b0001_1100_0000_0000;
  localparam logic [15:0] ST_MEMW = 16'b0000_0100_0000_0000;
  localparam logic [15:0] ST_MEMR = 16'b0000_0110_0000_0000;
  localparam logic [15:0] ST_T2   = 16'b0000_0001_1000_0000;
  localparam logic [15:0] ST_MFHI = 16'b0000_0000_0110_0100;
  localparam logic [15:0] ST_MFLO = 16'b0000_0000_0110_0001;
  localparam logic [15:0] ST_MTHI = 16'b0000_0000_0101_1000;
  localparam logic [15:0] ST_MTLO = 16'b0000_0000_0101_0010;

  typedef struct {
    string       name;
    logic        clr;
    logic        run;
    logic        rdy;
    logic        step;
    logic [4:0]  op;
    logic [15:0] strb;
    logic [4:0]  alu;
    logic        busy;
    logic        ei;
    logic        et;
    logic        done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string name, logic c, logic r, logic m, logic [4:0] op,
                              logic [15:0] s, logic [4:0] alu, logic b, logic ei,
                              logic et, logic d);
    vec_t v;
    v.name = name; v.clr = c; v.run = r; v.rdy = m; v.step = 1'b0; v.op = op;
    v.strb = s; v.alu = alu; v.busy = b; v.ei = ei; v.et = et; v.done = d;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    clr           = v.clr;
    bus.run       = v.run;
    bus.mem_ready = v.rdy;
    bus.opcode    = v.op;
`ifdef SINGLE_STEP_EN
    bus.step      = v.step;
`endif
  endtask

  task automatic checkOutput(input vec_t v);
    logic [15:0] s;
    s = {bus.PCout, bus.MARin, bus.Zin, bus.Zlowout, bus.PCin, bus.Read, bus.MDRin, bus.MDRout,
         bus.IRin, bus.Gra, bus.Rin, bus.Rout, bus.HIin, bus.HIout, bus.LOin, bus.LOout};
    checks++;
    if ({s, bus.alu_op, bus.busy, bus.err_illegal, bus.err_timeout, bus.instr_done} !==
        {v.strb, v.alu, v.busy, v.ei, v.et, v.done}) begin
      errors++;
      $display("[TB] FAIL %s: got strb=%b alu=%0d busy=%b ei=%b et=%b done=%b, want strb=%b alu=%0d busy=%b ei=%b et=%b done=%b",
               v.name, s, bus.alu_op, bus.busy, bus.err_illegal, bus.err_timeout, bus.instr_done,
               v.strb, v.alu, v.busy, v.ei, v.et, v.done);
    end
  endtask

  task automatic runCycle(input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput(v);
    @(posedge clk);
    #1;
  endtask

  // Only one driver may own the bus in any cycle.
  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if ($countones({bus.PCout, bus.Zlowout, bus.MDRout, bus.Rout, bus.HIout, bus.LOout}) > 1) begin
        errors++;
        $display("[TB] FAIL bus_exclusive: got %0d out-strobes high, want at most 1",
                 $countones({bus.PCout, bus.Zlowout, bus.MDRout, bus.Rout, bus.HIout, bus.LOout}));
      end
    end
  end

  task automatic runTable();
    tbl.push_back(mk("reset_idle",     0, 1, 1, MFHI, Z,       5'd0,  0, 0, 0, 0));
    tbl.push_back(mk("mfhi_t0",        0, 1, 1, MFHI, ST_T0,   5'd12, 1, 0, 0, 0));
    tbl.push_back(mk("mfhi_t1",        0, 1, 1, MFHI, ST_T1,   5'd0,  1, 0, 0, 0));
    tbl.push_back(mk("mfhi_memw",      0, 1, 1, MFHI, ST_MEMR, 5'd0,  1, 0, 0, 0));
    tbl.push_back(mk("mfhi_t2",        0, 1, 1, MFHI, ST_T2,   5'd0,  1, 0, 0, 0));
    tbl.push_back(mk("mfhi_t3",        0, 1, 1, MFHI, ST_MFHI, 5'd0,  1, 0, 0, 1));
    tbl.push_back(mk("mtlo_t0",        0, 0, 0, MTLO, ST_T0,   5'd12, 1, 0, 0, 0));
    tbl.push_back(mk("mtlo_t1",        0, 0, 0, MTLO, ST_T1,   5'd0,  1, 0, 0, 0));
    tbl.push_back(mk("mtlo_wait1",     0, 0, 0, MTLO, ST_MEMW, 5'd0,  1, 0, 0, 0));
    tbl.push_back(mk("mtlo_wait2",     0, 0, 0, MTLO, ST_MEMW, 5'd0,  1, 0, 0, 0));
    tbl.push_back(mk("mtlo_wait3",     0, 0, 0, MTLO, ST_MEMW, 5'd0,  1, 0, 0, 0));
    tbl.push_back(mk("mtlo_ready",     0, 0, 1, MTLO, ST_MEMR, 5'd0,  1, 0, 0, 0));
    tbl.push_back(mk("mtlo_t2",        0, 0, 0, MTLO, ST_T2,   5'd0,  1, 0, 0, 0));
    tbl.push_back(mk("mtlo_t3",        0, 0, 0, MTLO, ST_MTLO, 5'd0,  1, 0, 0, 1));
    tbl.push_back(mk("parked_idle",    0, 0, 0, MTLO, Z,       5'd0,  0, 0, 0, 0));
    tbl.push_back(mk("mflo_idle",      0, 1, 1, MFLO, Z,       5'd0,  0, 0, 0, 0));
    tbl.push_back(mk("mflo_t0",        0, 1, 1, MFLO, ST_T0,   5'd12, 1, 0, 0, 0));
    tbl.push_back(mk("mflo_t1",        0, 1, 1, MFLO, ST_T1,   5'd0,  1, 0, 0, 0));
    tbl.push_back(mk("mflo_memw",      0, 1, 1, MFLO, ST_MEMR, 5'd0,  1, 0, 0, 0));
    tbl.push_back(mk("mflo_t2",        0, 1, 1, MFLO, ST_T2,   5'd0,  1, 0, 0, 0));
    tbl.push_back(mk("mflo_t3",        0, 1, 1, MFLO, ST_MFLO, 5'd0,  1, 0, 0, 1));
    tbl.push_back(mk("ill_t0",         0, 1, 1, ILL,  ST_T0,   5'd12, 1, 0, 0, 0));
    tbl.push_back(mk("ill_t1",         0, 1, 1, ILL,  ST_T1,   5'd0,  1, 0, 0, 0));
    tbl.push_back(mk("ill_memw",       0, 1, 1, ILL,  ST_MEMR, 5'd0,  1, 0, 0, 0));
    tbl.push_back(mk("ill_t2",         0, 1, 1, ILL,  ST_T2,   5'd0,  1, 0, 0, 0));
    tbl.push_back(mk("ill_t3",         0, 1, 1, ILL,  Z,       5'd0,  1, 0, 0, 0));
    tbl.push_back(mk("ill_idle",       0, 0, 1, ILL,  Z,       5'd0,  0, 1, 0, 0));
    tbl.push_back(mk("ill_sticky",     0, 0, 1, ILL,  Z,       5'd0,  0, 1, 0, 0));
    foreach (tbl[i]) runCycle(tbl[i]);
  endtask

  task automatic runHandSequences();
    // Timeout: mem_ready never arrives; 15 MEMW cycles then back to IDLE with err_timeout.
    runCycle(mk("to_idle",  0, 1, 0, MFLO, Z,     5'd0,  0, 1, 0, 0));
    runCycle(mk("to_t0",    0, 1, 0, MFLO, ST_T0, 5'd12, 1, 1, 0, 0));
    runCycle(mk("to_t1",    0, 0, 0, MFLO, ST_T1, 5'd0,  1, 1, 0, 0));
    for (int i = 1; i <= 15; i++)
      runCycle(mk($sformatf("to_memw%0d", i), 0, 0, 0, MFLO, ST_MEMW, 5'd0, 1, 1, 0, 0));
    runCycle(mk("to_expired", 0, 0, 0, MFLO, Z, 5'd0, 0, 1, 1, 0));
    runCycle(mk("to_sticky",  0, 0, 0, MFLO, Z, 5'd0, 0, 1, 1, 0));

    // clr in the middle of MEMW wipes everything; run still high restarts at T0.
    runCycle(mk("clr_idle",  0, 1, 0, MTHI, Z,       5'd0,  0, 1, 1, 0));
    runCycle(mk("clr_t0",    0, 1, 0, MTHI, ST_T0,   5'd12, 1, 1, 1, 0));
    runCycle(mk("clr_t1",    0, 1, 0, MTHI, ST_T1,   5'd0,  1, 1, 1, 0));
    runCycle(mk("clr_memw1", 0, 1, 0, MTHI, ST_MEMW, 5'd0,  1, 1, 1, 0));
    runCycle(mk("clr_memw2", 1, 1, 0, MTHI, ST_MEMW, 5'd0,  1, 1, 1, 0));
    runCycle(mk("clr_after", 0, 1, 0, MTHI, Z,       5'd0,  0, 0, 0, 0));
    runCycle(mk("clr_new_t0", 0, 1, 0, MTHI, ST_T0,  5'd12, 1, 0, 0, 0));

    // Ready on the very cycle the counter hits WAIT_MAX: ready wins, no timeout.
    runCycle(mk("edge_t1", 0, 1, 0, MTHI, ST_T1, 5'd0, 1, 0, 0, 0));
    for (int i = 1; i <= 14; i++)
      runCycle(mk($sformatf("edge_memw%0d", i), 0, 1, 0, MTHI, ST_MEMW, 5'd0, 1, 0, 0, 0));
    runCycle(mk("edge_ready15", 0, 1, 1, MTHI, ST_MEMR, 5'd0, 1, 0, 0, 0));
    runCycle(mk("edge_t2",      0, 1, 0, MTHI, ST_T2,   5'd0, 1, 0, 0, 0));
    runCycle(mk("edge_t3",      0, 0, 0, MTHI, ST_MTHI, 5'd0, 1, 0, 0, 1));
    runCycle(mk("edge_idle",    0, 0, 0, MTHI, Z,       5'd0, 0, 0, 0, 0));
  endtask

`ifdef SINGLE_STEP_EN
  task automatic runStepTest();
    vec_t v;
    runCycle(mk("step_idle", 0, 1, 1, MFHI, Z, 5'd0, 0, 0, 0, 0));
    for (int w = 0; w < 3; w++) begin
      runCycle(mk("step_t0",   0, 1, 1, MFHI, ST_T0,   5'd12, 1, 0, 0, 0));
      runCycle(mk("step_t1",   0, 1, 1, MFHI, ST_T1,   5'd0,  1, 0, 0, 0));
      runCycle(mk("step_memw", 0, 1, 1, MFHI, ST_MEMR, 5'd0,  1, 0, 0, 0));
      runCycle(mk("step_t2",   0, 1, 1, MFHI, ST_T2,   5'd0,  1, 0, 0, 0));
      runCycle(mk("step_t3",   0, 1, 1, MFHI, ST_MFHI, 5'd0,  1, 0, 0, 1));
      for (int h = 0; h < 5; h++) begin
        v      = mk("step_hold", 0, 1, 1, MFHI, Z, 5'd0, 1, 0, 0, 0);
        v.step = (h == 4) && (w < 2);
        v.run  = !((h == 4) && (w == 2));
        runCycle(v);
      end
    end
    runCycle(mk("step_parked", 0, 0, 1, MFHI, Z, 5'd0, 0, 0, 0, 0));
  endtask
`endif

  initial begin
    clr           = 1'b1;
    bus.run       = 1'b0;
    bus.opcode    = '0;
    bus.mem_ready = 1'b0;
`ifdef SINGLE_STEP_EN
    bus.step      = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    clr   = 1'b0;
    armed = 1'b1;
`ifdef SINGLE_STEP_EN
    runStepTest();
`else
    runTable();
    runHandSequences();
`endif
    armed = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
